instruction_fetch: RTL

- Fetch stage of the 5-stage MIPS pipeline. Produces the instruction and next-PC pair that the decode stage consumes.
- Consumes decode's PC-redirect outputs: selpcsource, selpctype, rega, pcimd2ext, pcindex.
- Owns the PC register and a single-outstanding request/ready handshake to the instruction memory controller.
- MIPS one-instruction delay slot: a redirect takes effect after the in-flight fetch completes.

---
 rtl/instruction_fetch_if.sv | 28 ++
 rtl/instruction_fetch.sv | 131 +++++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch-to-instruction-memory request/ready bus
//
// Signals:
//   if_mc_en    fetch -> mem  request valid, held until mc_if_ready
//   if_mc_addr  fetch -> mem  request address (stable while if_mc_en)
//   mc_if_ready mem -> fetch  request complete, mc_if_data valid this cycle
//   mc_if_data  mem -> fetch  fetched instruction word
// Modports: master (fetch stage), slave (memory controller).
interface instruction_fetch_if;
    logic        if_mc_en;
    logic [31:0] if_mc_addr;
    logic        mc_if_ready;
    logic [31:0] mc_if_data;

    modport master (
        output if_mc_en,
        output if_mc_addr,
        input  mc_if_ready,
        input  mc_if_data
    );

    modport slave (
        input  if_mc_en,
        input  if_mc_addr,
        output mc_if_ready,
        output mc_if_data
    );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS fetch stage: PC register, single-outstanding imem request, delay-slot redirect
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   id_if_selpcsource      redirect requested this cycle (from decode)
//   id_if_selpctype        00 branch, 01 register, 10 jump index, 11 exception
//   id_if_pcimd2ext        branch target
//   id_if_rega             register target (jr/jalr)
//   id_if_pcindex          jump target
//   mc                     instruction memory bus (instruction_fetch_if.master)
//   if_id_instruc          registered instruction to decode, 0 = bubble
//   if_id_nextpc           registered PC+4 of if_id_instruc, 0 with a bubble
//   if_exc_misalign        misaligned redirect target pulse
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined:   misaligned redirect targets are replaced by EXC_VECTOR and
//              if_exc_misalign is raised in the cycle the redirect is sampled
//   undefined: target[1:0] is forced to 0 and if_exc_misalign is tied 0
module instruction_fetch #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       id_if_selpcsource,
    input  logic [1:0]                 id_if_selpctype,
    input  logic [31:0]                id_if_pcimd2ext,
    input  logic [31:0]                id_if_rega,
    input  logic [31:0]                id_if_pcindex,
    instruction_fetch_if.master        mc,
    output logic [31:0]                if_id_instruc,
    output logic [31:0]                if_id_nextpc,
    output logic                       if_exc_misalign
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] redirect_pc_q;
    logic        pending_q;
    logic        en_q;
    logic [31:0] instruc_q;
    logic [31:0] nextpc_q;

    logic [31:0] raw_target;
    logic [31:0] target_d;
    logic [31:0] pc_plus4;
    logic        misalign_d;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        raw_target = EXC_VECTOR;
        case (id_if_selpctype)
            2'b00:   raw_target = id_if_pcimd2ext;
            2'b01:   raw_target = id_if_rega;
            2'b10:   raw_target = id_if_pcindex;
            default: raw_target = EXC_VECTOR;
        endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic target_bad;
    assign target_bad = (raw_target[1:0] != 2'b00);
    assign target_d   = target_bad ? EXC_VECTOR : raw_target;
    // Only a redirect actually sampled (FETCH) raises the pulse; REDIR ignores decode.
    assign misalign_d = target_bad && id_if_selpcsource && (state_q == S_FETCH);
`else
    assign target_d   = raw_target & ~32'h3;
    assign misalign_d = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_BOOT;
            pc_q          <= PC_RESET;
            redirect_pc_q <= 32'h0;
            pending_q     <= 1'b0;
            en_q          <= 1'b0;
            instruc_q     <= 32'h0;
            nextpc_q      <= 32'h0;
        end else begin
            // Default: bubble towards decode unless a fetch completes below.
            instruc_q <= 32'h0;
            nextpc_q  <= 32'h0;
            case (state_q)
                S_BOOT: begin
                    state_q <= S_FETCH;
                    en_q    <= 1'b1;
                end
                S_FETCH: begin
                    if (mc.mc_if_ready) begin
                        instruc_q <= mc.mc_if_data;
                        nextpc_q  <= pc_plus4;
                        pc_q      <= id_if_selpcsource ? target_d : pc_plus4;
                    end else if (id_if_selpcsource) begin
                        // Delay slot still in flight: park the target until it lands.
                        redirect_pc_q <= target_d;
                        pending_q     <= 1'b1;
                        state_q       <= S_REDIR;
                    end
                end
                S_REDIR: begin
                    if (mc.mc_if_ready) begin
                        instruc_q <= mc.mc_if_data;
                        nextpc_q  <= pc_plus4;
                        pc_q      <= pending_q ? redirect_pc_q : pc_plus4;
                        pending_q <= 1'b0;
                        state_q   <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_BOOT;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mc.if_mc_en    = en_q;
    assign mc.if_mc_addr  = pc_q;
    assign if_id_instruc  = instruc_q;
    assign if_id_nextpc   = nextpc_q;
    assign if_exc_misalign = misalign_d;

endmodule
